// File: rtl/poly_small_collect.sv
// Small-polynomial collector: filters signed Gaussian samples to |s|<=127, forces odd
// coefficient-sum parity on the last slot, writes int8 coefficients and tracks norm/rejects.
module poly_small_collect #(
  parameter int LOGN = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            sample_req,
  input  logic            val_valid,
  input  logic [31:0]     val,
  output logic            coef_we,
  output logic [LOGN-1:0] coef_addr,
  output logic [7:0]      coef_data,
  output logic            done,
  output logic [31:0]     sqnorm,
  output logic [15:0]     rej_cnt,
  output logic [1:0]      state_dbg
);

  // Handshake: val_valid is a one-cycle strobe with no backpressure; a sample is
  // consumed only on a clock edge where the FSM is in RUN and val_valid is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LOGN-1:0] LAST_IDX = '1;

  state_t            state, state_nx;
  logic [LOGN-1:0]   u;
  logic              mod2;
  logic              in_range;
  logic              is_last;
  logic              accept;
  logic              reject;
  logic signed [7:0] s8;
  logic [15:0]       sq;

  assign s8       = val[7:0];
  assign sq       = 16'(s8 * s8);
  assign in_range = ($signed(val) >= -32'sd127) && ($signed(val) <= 32'sd127);
  assign is_last  = (u == LAST_IDX);

  // The final slot additionally needs the running coefficient sum to end up odd.
  assign accept = (state == RUN) && val_valid && in_range && (!is_last || (mod2 ^ val[0]));
  assign reject = (state == RUN) && val_valid && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && is_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u         <= '0;
      mod2      <= 1'b0;
      coef_we   <= 1'b0;
      coef_addr <= '0;
      coef_data <= '0;
      sqnorm    <= '0;
      rej_cnt   <= '0;
    end else begin
      coef_we <= accept;
      if (state == IDLE && start) begin
        u       <= '0;
        mod2    <= 1'b0;
        sqnorm  <= '0;
        rej_cnt <= '0;
      end
      if (accept) begin
        coef_addr <= u;
        coef_data <= val[7:0];
        sqnorm    <= sqnorm + {16'd0, sq};
        u         <= u + 1'b1;
        mod2      <= mod2 ^ val[0];
      end
      if (reject && rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
    end
  end

  assign busy       = (state != IDLE);
  assign sample_req = (state == RUN);
  assign done       = (state == DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_poly_small_collect.sv
// Randomized scoreboard bench for poly_small_collect with a sample-list reference model.
module tb_poly_small_collect;

  localparam int LOGN = 2;
  localparam int N    = 1 << LOGN;
  localparam int EW   = 1 + LOGN + 8 + 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            sample_req;
  logic            val_valid;
  logic [31:0]     val;
  logic            coef_we;
  logic [LOGN-1:0] coef_addr;
  logic [7:0]      coef_data;
  logic            done;
  logic [31:0]     sqnorm;
  logic [15:0]     rej_cnt;
  logic [1:0]      state_dbg;

  poly_small_collect #(.LOGN(LOGN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .sample_req(sample_req),
    .val_valid(val_valid), .val(val), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .done(done), .sqnorm(sqnorm), .rej_cnt(rej_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // expected write: {done, addr, data, sqnorm after write}
  logic [EW-1:0] exp_q[$];

  // reference model: phase 0=idle 1=running 2=finishing; accepted samples kept as a list
  int m_phase;
  int m_acc[$];
  int m_rej;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_sq();
    longint t = 0;
    foreach (m_acc[i]) t += longint'(m_acc[i]) * m_acc[i];
    return t;
  endfunction

  function automatic int model_sum();
    int t = 0;
    foreach (m_acc[i]) t += m_acc[i];
    return t;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_acc.delete();
    m_rej = 0;
  endtask

  task automatic model_edge(input logic st, input logic vv, input int s);
    bit ok;
    int pos;
    case (m_phase)
      0: if (st) begin m_acc.delete(); m_rej = 0; m_phase = 1; end
      1: if (vv) begin
        pos = m_acc.size();
        ok = (s >= -127) && (s <= 127);
        if (pos == N - 1) ok = ok && (((model_sum() + s) % 2) != 0);
        if (ok) begin
          m_acc.push_back(s);
          exp_q.push_back({(pos == N - 1), LOGN'(pos), 8'(s), 32'(model_sq())});
          if (pos == N - 1) m_phase = 2;
        end else if (m_rej < 65535) m_rej++;
      end
      default: m_phase = 0;
    endcase
  endtask

  // driver: one clock cycle of stimulus, then per-cycle status checks
  task automatic step(input logic st, input logic vv, input int s);
    start = st; val_valid = vv; val = s;
    @(posedge clk);
    model_edge(st, vv, s);
    #1;
    start = 1'b0; val_valid = 1'b0; val = '0;
    chk("busy", busy, m_phase != 0);
    chk("sample_req", sample_req, m_phase == 1);
    chk("sqnorm", sqnorm, model_sq());
    chk("rej_cnt", rej_cnt, m_rej);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && coef_we) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: addr %0d data %h with nothing expected", coef_addr, coef_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("write_word", {done, coef_addr, coef_data, sqnorm}, e);
      end
    end else if (rst_n && done) begin
      checks++; failures++;
      $display("FAIL stray_done: done=1 without final write");
    end
  end

  int sel, v;

  initial begin
    rst_n = 1'b0; start = 1'b0; val_valid = 1'b0; val = '0;
    model_reset();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_we", coef_we, 0);
    chk("rst_sqnorm", sqnorm, 0);
    chk("rst_rej", rej_cnt, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // directed: 3,-2,5,4,1 -> 4 rejected on parity
    step(1, 0, 0);
    step(0, 1, 3); step(0, 1, -2); step(0, 1, 5); step(0, 1, 4); step(0, 1, 1);
    chk("dir_done", done, 1);
    chk("dir_rej", rej_cnt, 1);
    chk("dir_sq", sqnorm, 39);
    step(0, 0, 0);
    chk("dir_idle", busy, 0);

    // val_valid while idle is ignored
    step(0, 1, 5); step(0, 1, 5);
    chk("idle_we", coef_we, 0);

    // range edges, start mid-run, consecutive ones
    step(1, 0, 0);
    step(0, 1, 128); step(0, 1, -128); step(0, 1, 127); step(0, 1, -127);
    chk("edge_rej", rej_cnt, 2);
    step(1, 0, 0);
    chk("midstart_sq", sqnorm, 127 * 127 * 2);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 3);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 3);
    step(0, 0, 0);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      step(1, 0, 0);
      for (int c = 0; c < 300 && m_phase != 0; c++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) v = int'($urandom);
        else if (sel == 1) v = ($urandom_range(0, 1) != 0) ? 128 : -128;
        else v = int'($urandom_range(0, 254)) - 127;
        step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, v);
      end
    end

    // asynchronous reset mid-run after two writes
    step(1, 0, 0);
    step(0, 1, 7); step(0, 1, -3); step(0, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_req", sample_req, 0);
    chk("arst_we", coef_we, 0);
    chk("arst_addr", coef_addr, 0);
    chk("arst_data", coef_data, 0);
    chk("arst_done", done, 0);
    chk("arst_sq", sqnorm, 0);
    chk("arst_rej", rej_cnt, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 2); step(0, 1, 0); step(0, 1, 0); step(0, 1, -1);
    step(0, 0, 0); step(0, 0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
